// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer memory arbiter.
// This package covers the bus states, the requester identities and the default sizes.
package fb_pkg;

  localparam int unsigned FB_AW    = 20;
  localparam int unsigned FB_BURST = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } fb_state_e;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } fb_req_e;

endpackage

// File: rtl/fb_mem_arbiter_if.sv
// This interface groups the display-read, frame-write and memory-bus signals of the arbiter.
// The master modport is the arbiter's view, because it masters the memory bus.
// The slave modport is the view used by the requesters and the memory.
interface fb_mem_arbiter_if #(
  parameter int unsigned AW    = 20,
  parameter int unsigned DW    = 32,
  parameter int unsigned LVL_W = 10
);

  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic [LVL_W-1:0] rd_level;
  logic             rd_gnt;
  logic             rd_valid;
  logic [DW-1:0]    rd_data;

  logic             wr_req;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             wr_gnt;
  logic             wr_ready;

  logic             mem_cyc;
  logic             mem_stb;
  logic             mem_we;
  logic [AW-1:0]    mem_adr;
  logic [DW-1:0]    mem_dat_o;
  logic             mem_ack;
  logic [DW-1:0]    mem_dat_i;

  modport master (
    input  rd_req, rd_addr, rd_level,
    output rd_gnt, rd_valid, rd_data,
    input  wr_req, wr_addr, wr_data,
    output wr_gnt, wr_ready,
    output mem_cyc, mem_stb, mem_we, mem_adr, mem_dat_o,
    input  mem_ack, mem_dat_i
  );

  modport slave (
    output rd_req, rd_addr, rd_level,
    input  rd_gnt, rd_valid, rd_data,
    output wr_req, wr_addr, wr_data,
    input  wr_gnt, wr_ready,
    input  mem_cyc, mem_stb, mem_we, mem_adr, mem_dat_o,
    output mem_ack, mem_dat_i
  );

endinterface

// File: rtl/fb_burst_counter.sv
// This module is the beat counter and word-address incrementer for one burst.
// Loading it restarts at beat 0. Each advance steps the beat and the address. last_o flags the final beat.
module fb_burst_counter #(
  parameter int unsigned AW    = 20,
  parameter int unsigned BURST = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [AW-1:0] addr_i,
  input  logic          advance_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  localparam int unsigned BW = $clog2(BURST);

  logic [BW-1:0] beat_q;
  logic [AW-1:0] addr_q;

  // The address wraps modulo 2^AW without any special handling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q <= '0;
      addr_q <= '0;
    end else if (load_i) begin
      beat_q <= '0;
      addr_q <= addr_i;
    end else if (advance_i) begin
      beat_q <= beat_q + BW'(1);
      addr_q <= addr_q + AW'(1);
    end
  end

  assign addr_o = addr_q;
  assign last_o = (beat_q == BW'(BURST - 1));

endmodule

// File: rtl/fb_mem_arbiter.sv
// This module arbitrates between display reads and frame writes for one framebuffer bus.
// An urgent display read wins outright. Otherwise the two requesters alternate round-robin.
module fb_mem_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned AW     = FB_AW,
  parameter int unsigned DW     = 32,
  parameter int unsigned BURST  = FB_BURST,
  parameter int unsigned LVL_W  = 10,
  parameter int unsigned LOW_WM = 64
) (
  input logic               pixel_clk,
  input logic               pixel_rst_n,
  fb_mem_arbiter_if.master  bus
);

  fb_state_e        state_q, state_d;
  fb_req_e          last_q, last_d;
  logic             rdGnt_q, rdGnt_d;
  logic             wrGnt_q, wrGnt_d;
  logic             load;
  logic [AW-1:0]    loadAddr;
  logic             lastBeat;
  logic             inBurst;
  logic             urgent;
  logic             pickRd;
  logic [LVL_W-1:0] level;

  assign level   = bus.rd_level;
  assign urgent  = bus.rd_req && (32'(level) < LOW_WM);
  assign pickRd  = bus.rd_req && (urgent || !bus.wr_req || (last_q == REQ_WR));
  assign inBurst = (state_q != IDLE);

  // Arbitration only happens in IDLE. Inside a burst, only the final acknowledged beat matters.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    rdGnt_d  = 1'b0;
    wrGnt_d  = 1'b0;
    load     = 1'b0;
    loadAddr = '0;
    case (state_q)
      IDLE: begin
        if (pickRd) begin
          state_d  = RD_BURST;
          last_d   = REQ_RD;
          rdGnt_d  = 1'b1;
          load     = 1'b1;
          loadAddr = bus.rd_addr;
        end else if (bus.wr_req) begin
          state_d  = WR_BURST;
          last_d   = REQ_WR;
          wrGnt_d  = 1'b1;
          load     = 1'b1;
          loadAddr = bus.wr_addr;
        end
      end
      RD_BURST, WR_BURST: begin
        if (bus.mem_ack && lastBeat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state_q <= IDLE;
      last_q  <= REQ_WR;
      rdGnt_q <= 1'b0;
      wrGnt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rdGnt_q <= rdGnt_d;
      wrGnt_q <= wrGnt_d;
    end
  end

  fb_burst_counter #(
    .AW    (AW),
    .BURST (BURST)
  ) u_counter (
    .clk_i     (pixel_clk),
    .rst_ni    (pixel_rst_n),
    .load_i    (load),
    .addr_i    (loadAddr),
    .advance_i (bus.mem_ack && inBurst),
    .addr_o    (bus.mem_adr),
    .last_o    (lastBeat)
  );

  assign bus.rd_gnt    = rdGnt_q;
  assign bus.wr_gnt    = wrGnt_q;
  assign bus.mem_cyc   = inBurst;
  assign bus.mem_stb   = inBurst;
  assign bus.mem_we    = (state_q == WR_BURST);
  assign bus.rd_valid  = bus.mem_ack && (state_q == RD_BURST);
  assign bus.wr_ready  = bus.mem_ack && (state_q == WR_BURST);
  assign bus.rd_data   = bus.mem_dat_i;
  assign bus.mem_dat_o = DW'(bus.wr_data);

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Shares one single-port framebuffer memory bus (Wishbone-classic style) between two requesters: the display line fetcher (read, feeds the pixel FIFO ahead of the VGA timing generator) and the frame writer (write, pattern/CPU side).
- Grants fixed-length bursts, drives the memory bus itself and counts beats on ack; display reads get absolute priority when the pixel FIFO is near underflow, otherwise alternate round-robin with writes.

Parameters:
- AW, 20, memory word-address width
- DW, 32, data width
- BURST, 16, beats per granted burst (power of two, >=2)
- LVL_W, 10, width of the pixel FIFO level input
- LOW_WM, 64, FIFO level below which a display read is urgent

Ports:
- pixel_clk  in  1  single clock for the whole block
- pixel_rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  display fetcher requests one read burst
- rd_addr  in  AW  start word address of the read burst
- rd_level  in  LVL_W  current pixel FIFO fill level
- rd_gnt  out  1  one-cycle pulse: read burst accepted
- rd_valid  out  1  read beat valid (equals mem_ack during read burst)
- rd_data  out  DW  read beat data (mem_dat_i passthrough)
- wr_req  in  1  frame writer requests one write burst
- wr_addr  in  AW  start word address of the write burst
- wr_data  in  DW  current write beat data (held until wr_ready)
- wr_gnt  out  1  one-cycle pulse: write burst accepted
- wr_ready  out  1  write beat consumed (equals mem_ack during write burst)
- mem_cyc, mem_stb  out  1  bus cycle / strobe
- mem_we  out  1  1 = write
- mem_adr  out  AW  word address
- mem_dat_o  out  DW  write data (wr_data passthrough)
- mem_ack  in  1  beat acknowledge
- mem_dat_i  in  DW  read data

Behaviour:
- Reset (async, any time incl. mid-burst): state IDLE, beat counter 0, last-served = WR (so first tie goes to read); mem_cyc/mem_stb/mem_we/rd_gnt/wr_gnt = 0, mem_adr = 0; rd_valid/wr_ready = 0. Interrupted burst is abandoned; requesters must re-request.
- States: IDLE, RD_BURST, WR_BURST.
- IDLE arbitration (evaluated only in IDLE): urgent = rd_req && (rd_level < LOW_WM).
  - urgent -> RD_BURST.
  - else both req -> opposite of last-served.
  - else the single requester; none -> stay IDLE.
- On entering a burst (registered): gnt pulse high exactly one cycle, same cycle mem_cyc=mem_stb=1, mem_we=1 only for WR_BURST, mem_adr = latched start address; beat = 0; last-served updated.
- In burst: cyc/stb held high continuously; on each mem_ack, beat++ and mem_adr++ (modulo 2^AW, wraps silently). rd_valid = mem_ack && RD_BURST; wr_ready = mem_ack && WR_BURST; both combinational.
- Ack with beat == BURST-1: next cycle IDLE, cyc/stb/we low. At least one idle cycle between bursts; arbitration re-runs there.
- Request inputs and rd_level are ignored during a burst (no abort, no preemption). A req still high after its burst completes is treated as a new request.
- mem_ack outside a burst is ignored.
- Latency: request seen in IDLE at edge N -> gnt and stb visible after edge N+1; min burst duration = BURST cycles with ack tied high.
- Simultaneous: urgent read beats any write regardless of round-robin state; round-robin pointer still updated to RD.

Decomposition:
- Shared package fb_pkg: state enum (IDLE, RD_BURST, WR_BURST), requester enum (REQ_RD, REQ_WR), BURST/AW defaults.
- One natural sub-module: fb_burst_counter (beat counter + address incrementer with last-beat flag); arbiter FSM stays in top.

Test Plan:
- Reset release, rd_req=1, rd_addr=0x00100, ack tied 1 -> rd_gnt one pulse, 16 rd_valid beats, mem_adr 0x00100..0x0010F, then cyc low for >=1 cycle.
- rd_req and wr_req both held high, rd_level=500, ack tied 1 -> grants alternate RD, WR, RD, WR; mem_we=1 only on WR bursts.
- Last burst RD, both req, rd_level=10 -> RD granted again (urgent overrides round-robin).
- wr_addr=0xFFFF8, ack every 3rd cycle -> mem_adr wraps 0xFFFFF->0x00000, 16 wr_ready pulses, mem_dat_o tracks wr_data each beat.
- pixel_rst_n asserted at beat 7 of a read burst -> outputs 0 immediately (async); after release, new request restarts at beat 0 with fresh gnt.
- Spurious mem_ack in IDLE, no req -> no rd_valid/wr_ready, state stays IDLE.
